// File: rtl/sound_pkg.sv
// Shared sound codes, scheduler state encoding and the per-cycle event
// resolver used by the sound request scheduler.
package sound_pkg;

   typedef enum logic [2:0] {
      SND_NONE     = 3'd0,
      SND_SELECT   = 3'd1,
      SND_DESELECT = 3'd2,
      SND_MOVE     = 3'd3,
      SND_CAPTURE  = 3'd4,
      SND_ILLEGAL  = 3'd5,
      SND_PROMOTE  = 3'd6,
      SND_GAMEOVER = 3'd7
   } snd_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_GAP
   } sched_state_t;

   typedef struct packed {
      logic       vld;
      logic [2:0] code;
      logic [2:0] ndrop;
   } ev_res_t;

   // Highest set request bit wins; every other set bit is a discarded request.
   function automatic ev_res_t resolve_events(input logic [7:0] req);
      ev_res_t    r;
      logic [2:0] n;
      r = '0;
      n = '0;
      for (int k = 1; k < 8; k++) begin
         if (req[k]) begin
            r.vld  = 1'b1;
            r.code = 3'(k);
            n      = n + 3'd1;
         end
      end
      r.ndrop = r.vld ? (n - 3'd1) : 3'd0;
      return r;
   endfunction

endpackage

// File: rtl/sound_fifo.sv
// Small synchronous FIFO of sound codes with flush and tail visibility.
// Flush together with push leaves exactly the pushed entry.
module sound_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 3,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic [W-1:0]  tail,
   output logic [LW-1:0] level,
   output logic          empty,
   output logic          full
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;
   logic          do_push;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign head    = mem[rd_ptr];
   assign tail    = mem[wr_ptr - AW'(1)];
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so a full queue may still accept.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         if (push) begin
            mem[0] <= din;
            wr_ptr <= AW'(1);
            level  <= LW'(1);
         end else begin
            wr_ptr <= '0;
            level  <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/sound_request_scheduler.sv
// Collects one-cycle game sound events, queues them and hands them to the
// PWM sound player one at a time with a silent gap between sounds.
module sound_request_scheduler #(
   parameter int DEPTH         = 4,
   parameter int GAP_CYCLES    = 1000000,
   parameter int START_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] ev_req,
   input  logic       player_busy,
   output logic       play_sound,
   output logic [2:0] sound_code,
   output logic [2:0] queue_level,
   output logic [7:0] drop_cnt,
   output logic       timeout_flag
);
   import sound_pkg::*;

   localparam int LW   = $clog2(DEPTH) + 1;
   localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
   localparam int TW   = $clog2(TMAX) + 1;

   ev_res_t      res;
   logic         is_go;
   logic         coalesce;
   logic         ovf;
   logic         push;
   logic         pop;
   logic [2:0]   head;
   logic [2:0]   tail;
   logic [LW-1:0] level;
   logic         empty;
   logic         full;
   logic [3:0]   drop_inc;
   logic [8:0]   drop_sum;

   sched_state_t  state;
   sched_state_t  state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic          set_to;

   always_comb res = resolve_events(ev_req);

   // Coalescing looks at the tail as it stands before this cycle's pop.
   assign is_go    = res.vld && (res.code == SND_GAMEOVER);
   assign coalesce = res.vld && !is_go && !empty && (res.code == tail);
   assign ovf      = res.vld && !is_go && !coalesce && full && !pop;
   assign push     = res.vld && !coalesce && !ovf;
   assign drop_inc = {1'b0, res.ndrop} + {3'b0, ovf};
   assign drop_sum = {1'b0, drop_cnt} + {5'b0, drop_inc};

   sound_fifo #(
      .DEPTH (DEPTH),
      .W     (3)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (res.code),
      .pop   (pop),
      .flush (is_go),
      .head  (head),
      .tail  (tail),
      .level (level),
      .empty (empty),
      .full  (full)
   );

   assign queue_level = 3'(level);

   // The head is latched and popped on the same edge that enters ISSUE, so a
   // flush landing on that edge cannot separate the issued code from the pop.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      pop        = 1'b0;
      set_to     = 1'b0;
      play_sound = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty && !player_busy) begin
               state_nxt = ST_ISSUE;
               pop       = 1'b1;
            end
         end
         ST_ISSUE: begin
            play_sound = 1'b1;
            state_nxt  = ST_WAIT_START;
            timer_nxt  = '0;
         end
         ST_WAIT_START: begin
            if (player_busy) begin
               state_nxt = ST_WAIT_DONE;
            end else if (timer == TW'(START_TIMEOUT - 1)) begin
               set_to    = 1'b1;
               state_nxt = ST_GAP;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!player_busy) begin
               state_nxt = ST_GAP;
               timer_nxt = '0;
            end
         end
         ST_GAP: begin
            if (timer == TW'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
            else                              timer_nxt = timer + TW'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= ST_IDLE;
         timer        <= '0;
         sound_code   <= '0;
         timeout_flag <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (pop)    sound_code   <= head;
         if (set_to) timeout_flag <= 1'b1;
         drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Scoreboard bench: a behavioural queue model predicts issued codes and drop
// counts; a negedge monitor compares every play_sound pulse against it.
module tb_sound_request_scheduler;

   localparam int DEPTH = 4;
   localparam int G     = 20;
   localparam int T     = 16;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] ev_req;
   logic       player_busy;
   logic       play_sound;
   logic [2:0] sound_code;
   logic [2:0] queue_level;
   logic [7:0] drop_cnt;
   logic       timeout_flag;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int n_issue = 0;
   int last_issue_cyc = 0;
   int mq[$];
   int exp_drop = 0;

   sound_request_scheduler #(
      .DEPTH         (DEPTH),
      .GAP_CYCLES    (G),
      .START_TIMEOUT (T)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .ev_req       (ev_req),
      .player_busy  (player_busy),
      .play_sound   (play_sound),
      .sound_code   (sound_code),
      .queue_level  (queue_level),
      .drop_cnt     (drop_cnt),
      .timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Reference rules for one cycle of requests against the pending queue.
   task automatic model_ev(input logic [7:0] req);
      int n = 0;
      int w = 0;
      for (int k = 1; k < 8; k++) if (req[k]) begin n++; w = k; end
      if (n == 0) return;
      exp_drop += n - 1;
      if (w == 7) begin
         mq.delete();
         mq.push_back(7);
      end else if (mq.size() > 0 && mq[$] == w) begin
      end else if (mq.size() >= DEPTH) begin
         exp_drop++;
      end else begin
         mq.push_back(w);
      end
      if (exp_drop > 255) exp_drop = 255;
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1 && play_sound === 1'b1) begin
         n_issue++;
         last_issue_cyc = cyc;
         if (mq.size() == 0) chk("issue_unexpected", 32'(sound_code), 32'd8);
         else                chk("issue_code", 32'(sound_code), mq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] req);
      ev_req = req;
      model_ev(req);
      step();
      ev_req = 8'h00;
   endtask

   task automatic wait_issue(input int budget);
      int start = n_issue;
      int i = 0;
      while (n_issue == start && i < budget) begin step(); i++; end
      if (n_issue == start) chk("issue_wait_timeout", n_issue, start + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, f0, p, n0;
      rstn = 1'b0;
      ev_req = 8'h00;
      player_busy = 1'b0;
      #23;
      chk("rst_play", play_sound, 0);
      chk("rst_code", sound_code, 0);
      chk("rst_level", queue_level, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_timeout", timeout_flag, 0);
      rstn = 1'b1;
      step();

      // Single event latency and gap timing
      t0 = cyc;
      send(8'b0000_1000);
      @(negedge clk);
      chk("lat_n1_play", play_sound, 0);
      chk("lat_n1_level", queue_level, 1);
      step();
      @(negedge clk);
      chk("lat_n2_play", play_sound, 1);
      chk("lat_n2_code", sound_code, 3);
      step();
      player_busy = 1'b1;
      while (cyc < t0 + 10) step();
      send(8'b0000_0100);
      while (cyc < t0 + 51) step();
      player_busy = 1'b0;
      wait_issue(G + 20);
      chk("gap_issue_cyc", last_issue_cyc - t0, 53 + G);
      player_busy = 1'b1;
      repeat (5) step();
      player_busy = 1'b0;
      step();
      player_busy = 1'b1;

      // Simultaneous events
      send(8'b0011_0010);
      @(negedge clk);
      chk("simul_level", queue_level, 1);
      chk("simul_drop", drop_cnt, 2);
      chk("simul_drop_model", drop_cnt, exp_drop);
      player_busy = 1'b0;
      wait_issue(G + 20);
      player_busy = 1'b1;

      // Overflow then coalesce while the player is busy
      send(8'h02); send(8'h04); send(8'h08); send(8'h10); send(8'h20);
      @(negedge clk);
      chk("ovf_level", queue_level, 4);
      chk("ovf_drop", drop_cnt, 3);
      step();
      send(8'h10);
      @(negedge clk);
      chk("coal_level", queue_level, mq.size());
      chk("coal_drop", drop_cnt, exp_drop);

      // Game-over flush
      step();
      send(8'h80);
      @(negedge clk);
      chk("go_level", queue_level, 1);
      chk("go_drop", drop_cnt, 3);
      step();
      f0 = cyc;
      player_busy = 1'b0;
      wait_issue(G + 20);
      chk("go_issue_cyc", last_issue_cyc - f0, G + 2);

      // Start timeout: player never responds
      p = last_issue_cyc;
      send(8'h40);
      while (cyc < p + 16) step();
      @(negedge clk);
      chk("to_before", timeout_flag, 0);
      step();
      @(negedge clk);
      chk("to_after", timeout_flag, 1);
      wait_issue(G + 20);
      chk("to_issue_cyc", last_issue_cyc - p, 18 + G);
      chk("to_sticky", timeout_flag, 1);

      // Async reset in WAIT_DONE
      player_busy = 1'b1;
      send(8'h08);
      repeat (3) step();
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_play", play_sound, 0);
      chk("arst_code", sound_code, 0);
      chk("arst_level", queue_level, 0);
      chk("arst_drop", drop_cnt, 0);
      chk("arst_timeout", timeout_flag, 0);
      mq.delete();
      exp_drop = 0;
      player_busy = 1'b0;
      #29;
      rstn = 1'b1;
      n0 = n_issue;
      repeat (30) step();
      chk("arst_no_issue", n_issue, n0);
      t0 = cyc;
      send(8'h10);
      wait_issue(6);
      chk("arst_new_issue_cyc", last_issue_cyc - t0, 2);
      chk("final_drop", drop_cnt, exp_drop);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
